// File: rtl/pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Purpose  : Fetch-stage program counter with branch/jump/call/return and a
//            built-in circular return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      INC       = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      RAS_DEPTH = 4,
    parameter int unsigned      ALIGN     = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 stall,
    input  logic [2:0]                           op,
    input  logic                                 cond,
    input  logic [WIDTH-1:0]                     offset,
    input  logic [WIDTH-1:0]                     target,
    output logic [WIDTH-1:0]                     pc,
    output logic [WIDTH-1:0]                     link,
    output logic [$clog2(RAS_DEPTH+1)-1:0]       ras_count,
    output logic                                 ras_err
);

    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    localparam logic [2:0] c_OP_SEQ  = 3'd0;
    localparam logic [2:0] c_OP_BR   = 3'd1;
    localparam logic [2:0] c_OP_JMP  = 3'd2;
    localparam logic [2:0] c_OP_CALL = 3'd3;
    localparam logic [2:0] c_OP_RET  = 3'd4;

    localparam logic [WIDTH-1:0] c_ALIGN_MASK = ~((WIDTH'(1) << ALIGN) - WIDTH'(1));

    logic [WIDTH-1:0] r_pc;
    logic [CW-1:0]    r_count;
    logic             r_err;
    logic [PW-1:0]    r_ptr;          // next free slot; top entry sits at r_ptr-1
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];

    logic [WIDTH-1:0] w_link;
    logic [WIDTH-1:0] w_next;
    logic [PW-1:0]    w_ptr_inc;
    logic [PW-1:0]    w_ptr_dec;
    logic             w_push;
    logic             w_pop;
    logic             w_under;
    logic             w_full;

    assign w_link    = r_pc + WIDTH'(INC);
    assign w_ptr_inc = (r_ptr == PW'(RAS_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
    assign w_ptr_dec = (r_ptr == '0) ? PW'(RAS_DEPTH - 1) : r_ptr - 1'b1;
    assign w_full    = (r_count == CW'(RAS_DEPTH));

    always_comb begin
        w_next  = w_link;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_under = 1'b0;
        case (op)
            c_OP_BR: begin
                if (cond) begin
                    w_next = r_pc + offset;
                end
            end
            c_OP_JMP: begin
                w_next = target;
            end
            c_OP_CALL: begin
                w_next = target;
                w_push = 1'b1;
            end
            c_OP_RET: begin
                if (r_count != '0) begin
                    w_next = r_ras[w_ptr_dec];
                    w_pop  = 1'b1;
                end else begin
                    w_under = 1'b1;
                end
            end
            default: begin
                w_next = w_link;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_VEC & c_ALIGN_MASK;
            r_count <= '0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
        end else if (!stall) begin
            r_pc <= w_next & c_ALIGN_MASK;
            if (w_push) begin
                // A push onto a full stack overwrites the oldest entry in place.
                r_ptr <= w_ptr_inc;
                if (w_full) begin
                    r_err <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_pop) begin
                r_ptr   <= w_ptr_dec;
                r_count <= r_count - 1'b1;
            end
            if (w_under) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !stall && w_push) begin
            r_ras[r_ptr] <= w_link;
        end
    end

    assign pc        = r_pc;
    assign link      = w_link;
    assign ras_count = r_count;
    assign ras_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// ============================================================================
// Module   : tb_pc_unit
// Purpose  : Directed self-checking bench for pc_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  op;
    logic        cond;
    logic [31:0] offset;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] link;
    logic [2:0]  ras_count;
    logic        ras_err;

    int n_total;
    int n_pass;

    localparam logic [2:0] SEQ  = 3'd0;
    localparam logic [2:0] BR   = 3'd1;
    localparam logic [2:0] JMP  = 3'd2;
    localparam logic [2:0] CALL = 3'd3;
    localparam logic [2:0] RET  = 3'd4;

    pc_unit #(
        .WIDTH    (32),
        .INC      (4),
        .RESET_VEC(32'h0),
        .RAS_DEPTH(4),
        .ALIGN    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .op       (op),
        .cond     (cond),
        .offset   (offset),
        .target   (target),
        .pc       (pc),
        .link     (link),
        .ras_count(ras_count),
        .ras_err  (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; op = SEQ; cond = 1'b0; offset = '0; target = '0;
        step();
        rst = 1'b0;
        n_total++;
        if ({pc, ras_count, ras_err} !== {32'h0, 3'd0, 1'b0}) begin
            $display("FAIL reset: pc=%h cnt=%0d err=%b, required pc=0 cnt=0 err=0", pc, ras_count, ras_err);
        end else n_pass++;
        n_total++;
        if (link !== 32'h4) $display("FAIL reset_link: got %h, required 4", link);
        else n_pass++;
    endtask

    task automatic test_seq();
        op = SEQ;
        for (int i = 1; i <= 5; i++) begin
            step();
            n_total++;
            if (pc !== 32'(i * 4) || link !== 32'(i * 4 + 4)) begin
                $display("FAIL seq[%0d]: pc=%h link=%h, required pc=%h link=%h", i, pc, link, i * 4, i * 4 + 4);
            end else n_pass++;
        end
    endtask

    task automatic test_branch();
        op = JMP; target = 32'h20; step();
        n_total++;
        if (pc !== 32'h20) $display("FAIL jmp_20: got %h, required 00000020", pc);
        else n_pass++;
        op = BR; offset = 32'hFFFF_FFF8; cond = 1'b1; step();
        n_total++;
        if (pc !== 32'h18) $display("FAIL br_taken: got %h, required 00000018", pc);
        else n_pass++;
        cond = 1'b0; step();
        n_total++;
        if (pc !== 32'h1C) $display("FAIL br_not_taken: got %h, required 0000001c", pc);
        else n_pass++;
        op = JMP; target = 32'h103; step();
        n_total++;
        if (pc !== 32'h100) $display("FAIL jmp_align: got %h, required 00000100", pc);
        else n_pass++;
        op = BR; cond = 1'b1; offset = 32'h6; step();
        n_total++;
        if (pc !== 32'h104) $display("FAIL br_align: got %h, required 00000104", pc);
        else n_pass++;
    endtask

    task automatic test_call_ret();
        logic [31:0] exp_pc [4];
        logic [2:0]  exp_cn [4];
        logic [2:0]  ops    [4];
        logic [31:0] tgts   [4];
        exp_pc = '{32'h100, 32'h200, 32'h104, 32'h14};
        exp_cn = '{3'd1, 3'd2, 3'd1, 3'd0};
        ops    = '{CALL, CALL, RET, RET};
        tgts   = '{32'h100, 32'h200, 32'h0, 32'h0};
        op = JMP; target = 32'h10; cond = 1'b0; step();
        for (int i = 0; i < 4; i++) begin
            op = ops[i]; target = tgts[i]; step();
            n_total++;
            if ({pc, ras_count, ras_err} !== {exp_pc[i], exp_cn[i], 1'b0}) begin
                $display("FAIL call_ret[%0d]: pc=%h cnt=%0d err=%b, required pc=%h cnt=%0d err=0",
                         i, pc, ras_count, ras_err, exp_pc[i], exp_cn[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ret [5];
        exp_ret = '{32'h4004, 32'h3004, 32'h2004, 32'h1004, 32'h1008};
        // Pushes 0x18, 0x1004, 0x2004, 0x3004, 0x4004; the fifth drops 0x18.
        for (int i = 1; i <= 5; i++) begin
            op = CALL; target = 32'(i * 32'h1000); step();
            n_total++;
            if ({pc, ras_count, ras_err} !== {32'(i * 32'h1000), 3'(i > 4 ? 4 : i), 1'(i == 5)}) begin
                $display("FAIL ovf_call[%0d]: pc=%h cnt=%0d err=%b, required pc=%h cnt=%0d err=%0d",
                         i, pc, ras_count, ras_err, i * 32'h1000, (i > 4 ? 4 : i), (i == 5));
            end else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            op = RET; step();
            n_total++;
            if ({pc, ras_count, ras_err} !== {exp_ret[i], 3'(i < 4 ? 3 - i : 0), 1'b1}) begin
                $display("FAIL ovf_ret[%0d]: pc=%h cnt=%0d err=%b, required pc=%h cnt=%0d err=1",
                         i, pc, ras_count, ras_err, exp_ret[i], (i < 4 ? 3 - i : 0));
            end else n_pass++;
        end
    endtask

    task automatic test_stall();
        stall = 1'b1; op = CALL; target = 32'h300; cond = 1'b1; offset = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if ({pc, ras_count, ras_err} !== {32'h1008, 3'd0, 1'b1}) begin
                $display("FAIL stall[%0d]: pc=%h cnt=%0d err=%b, required pc=00001008 cnt=0 err=1",
                         i, pc, ras_count, ras_err);
            end else n_pass++;
        end
        stall = 1'b0; step();
        n_total++;
        if ({pc, ras_count} !== {32'h300, 3'd1}) begin
            $display("FAIL stall_release: pc=%h cnt=%0d, required pc=00000300 cnt=1", pc, ras_count);
        end else n_pass++;
        op = RET; step();
        n_total++;
        if ({pc, ras_count} !== {32'h100C, 3'd0}) begin
            $display("FAIL stall_ret: pc=%h cnt=%0d, required pc=0000100c cnt=0", pc, ras_count);
        end else n_pass++;
    endtask

    task automatic test_wrap_reset();
        op = JMP; target = 32'hFFFF_FFFC; step();
        n_total++;
        if (link !== 32'h0) $display("FAIL wrap_link: got %h, required 00000000", link);
        else n_pass++;
        op = SEQ; step();
        n_total++;
        if (pc !== 32'h0) $display("FAIL wrap_seq: got %h, required 00000000", pc);
        else n_pass++;
        op = CALL; target = 32'h40; step();
        target = 32'h80; step();
        n_total++;
        if ({pc, ras_count, ras_err} !== {32'h80, 3'd2, 1'b1}) begin
            $display("FAIL pre_reset: pc=%h cnt=%0d err=%b, required pc=00000080 cnt=2 err=1",
                     pc, ras_count, ras_err);
        end else n_pass++;
        rst = 1'b1; op = CALL; target = 32'h500; step();
        rst = 1'b0;
        n_total++;
        if ({pc, ras_count, ras_err} !== {32'h0, 3'd0, 1'b0}) begin
            $display("FAIL mid_reset: pc=%h cnt=%0d err=%b, required pc=0 cnt=0 err=0",
                     pc, ras_count, ras_err);
        end else n_pass++;
        op = RET; step();
        n_total++;
        if ({pc, ras_count, ras_err} !== {32'h4, 3'd0, 1'b1}) begin
            $display("FAIL post_reset_underflow: pc=%h cnt=%0d err=%b, required pc=4 cnt=0 err=1",
                     pc, ras_count, ras_err);
        end else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; stall = 1'b0; op = SEQ; cond = 1'b0; offset = '0; target = '0;
        #1;
        test_reset();
        test_seq();
        test_branch();
        test_call_ret();
        test_overflow();
        test_stall();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
